popcount_pipe: RTL and testbench

- Parametrised, pipelined population-count unit: counts set bits of an IN_W-bit word through a registered binary adder tree.
- Adds a valid/ready stream interface with backpressure.
- Adds an accumulate mode that sums counts across a multi-beat packet, with saturation.
- Serves as the registered, streaming successor to the team's combinational bit-count adders; used wherever ones-counts of wide vectors feed downstream logic at clock rate.

---
 rtl/popcount_pipe.sv | 176 +++++++++++++++++
 tb/tb_popcount_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_pipe.sv
// ---------------------------------------------------------------------------
// popcount_pipe
//
// Pipelined population count with a valid/ready stream interface and an
// optional per-packet accumulate mode with saturation.
//
// Each accepted word walks through LAT registered adder-tree levels. A final
// output register either presents the word's count directly (mode 0) or folds
// it into a saturating accumulator that is reported on the packet's last beat
// (mode 1). The whole pipe stalls as one unit when the output is held.
//
// Parameters
//   IN_W   input word width in bits (1..256)
//   ACC_W  accumulator / result width (must be >= CNT_W)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   in_data    word whose set bits are counted
//   in_last    final beat of a packet (mode 1 only)
//   in_mode    0 = per-word count, 1 = accumulate; travels with the beat
//   out_valid  result valid
//   out_ready  downstream accept
//   out_count  result, zero-extended to ACC_W
//   out_sat    result was clamped (mode 1 only, 0 in mode 0)
// ---------------------------------------------------------------------------
module popcount_pipe #(
  parameter int IN_W  = 7,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_sat
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int LAT   = ($clog2(IN_W) < 1) ? 1 : $clog2(IN_W);
  // Number of pair sums produced by any level; later levels use a prefix of it.
  localparam int HALF  = (IN_W + 1) / 2;

  if (IN_W < 1 || IN_W > 256) begin : g_bad_in_w
    $error("popcount_pipe: IN_W must be in 1..256");
  end
  if (ACC_W < CNT_W) begin : g_bad_acc_w
    $error("popcount_pipe: ACC_W must be >= clog2(IN_W+1)");
  end

  // Every tree level is stored as IN_W+1 entries of CNT_W bits. Entries past
  // the live count of a level are always zero, so an odd leftover element is
  // simply added to a zero neighbour and passes through unchanged.
  logic [CNT_W-1:0] tree_d [LAT][IN_W+1];
  logic [CNT_W-1:0] tree_q [LAT][IN_W+1];
  logic [LAT-1:0]   vld_q;
  logic [LAT-1:0]   mode_q;
  logic [LAT-1:0]   last_q;

  logic [IN_W:0]    bits_pad;
  logic             advance;

  logic [ACC_W-1:0] acc_q;
  logic             sticky_q;
  logic [CNT_W-1:0] word_cnt;
  logic [ACC_W:0]   acc_sum;
  logic             add_sat;
  logic [ACC_W-1:0] acc_next;

  // Sums at level lv need at most lv+2 bits. Masking the rest lets synthesis
  // drop the upper bits of the early levels, so widths grow one bit per level.
  function automatic logic [CNT_W-1:0] level_mask(input int lv);
    logic [CNT_W-1:0] m;
    m = '0;
    for (int b = 0; b < CNT_W; b++) begin
      if (b < lv + 2) m[b] = 1'b1;
    end
    return m;
  endfunction

  // The whole pipe moves together; only a held output result can stop it.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  assign bits_pad = {1'b0, in_data};

  always_comb begin
    for (int lv = 0; lv < LAT; lv++) begin
      for (int i = 0; i <= IN_W; i++) begin
        tree_d[lv][i] = '0;
      end
    end
    for (int i = 0; i < HALF; i++) begin
      tree_d[0][i] = (CNT_W'(bits_pad[2*i]) + CNT_W'(bits_pad[2*i+1])) & level_mask(0);
    end
    for (int lv = 1; lv < LAT; lv++) begin
      for (int i = 0; i < HALF; i++) begin
        tree_d[lv][i] = (tree_q[lv-1][2*i] + tree_q[lv-1][2*i+1]) & level_mask(lv);
      end
    end
  end

  // Bubbles shift along with real beats; mode and last ride beside each level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int lv = 0; lv < LAT; lv++) begin
        for (int i = 0; i <= IN_W; i++) begin
          tree_q[lv][i] <= '0;
        end
      end
      vld_q  <= '0;
      mode_q <= '0;
      last_q <= '0;
    end else if (advance) begin
      for (int lv = 0; lv < LAT; lv++) begin
        for (int i = 0; i <= IN_W; i++) begin
          tree_q[lv][i] <= tree_d[lv][i];
        end
      end
      vld_q[0]  <= in_valid;
      mode_q[0] <= in_mode;
      last_q[0] <= in_last;
      for (int lv = 1; lv < LAT; lv++) begin
        vld_q[lv]  <= vld_q[lv-1];
        mode_q[lv] <= mode_q[lv-1];
        last_q[lv] <= last_q[lv-1];
      end
    end
  end

  assign word_cnt = tree_q[LAT-1][0];

  // One extra bit catches the carry out; the sum can never exceed twice the
  // accumulator range, so a single carry bit is enough to detect a clamp.
  assign acc_sum  = {1'b0, acc_q} + (ACC_W+1)'(word_cnt);
  assign add_sat  = acc_sum[ACC_W];
  assign acc_next = add_sat ? '1 : acc_sum[ACC_W-1:0];

  // Mode 0 beats bypass the accumulator so an open mode-1 packet survives
  // interleaved single-word counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_count <= '0;
      out_sat   <= 1'b0;
      acc_q     <= '0;
      sticky_q  <= 1'b0;
    end else if (advance) begin
      out_valid <= 1'b0;
      if (vld_q[LAT-1]) begin
        if (!mode_q[LAT-1]) begin
          out_valid <= 1'b1;
          out_count <= ACC_W'(word_cnt);
          out_sat   <= 1'b0;
        end else if (last_q[LAT-1]) begin
          out_valid <= 1'b1;
          out_count <= acc_next;
          out_sat   <= sticky_q | add_sat;
          acc_q     <= '0;
          sticky_q  <= 1'b0;
        end else begin
          acc_q     <= acc_next;
          sticky_q  <= sticky_q | add_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_popcount_pipe.sv
// ---------------------------------------------------------------------------
// tb_popcount_pipe
//
// Drives one shared 8-bit beat stream into two popcount_pipe instances:
//   dut a: IN_W=7, ACC_W=16 (sees the low 7 bits)
//   dut b: IN_W=8, ACC_W=4  (small accumulator, saturates easily)
// Each instance has its own reference model and expected-result queue.
// ---------------------------------------------------------------------------
module tb_popcount_pipe;

  typedef struct packed {
    logic [31:0] cnt;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_mode = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  in_data = '0;

  logic        in_ready_a, out_valid_a, out_sat_a;
  logic [15:0] out_count_a;
  logic        in_ready_b, out_valid_b, out_sat_b;
  logic [3:0]  out_count_b;

  int          checks = 0;
  int          errors = 0;
  int          stall_cnt = 0;
  logic        rand_done = 1'b0;

  exp_t        exp_q [2][$];
  int          acc_m [2];
  logic        sticky_m [2];
  logic        hold_v [2];
  logic [31:0] hold_c [2];
  logic        hold_s [2];

  always #5 clk = ~clk;

  popcount_pipe #(.IN_W(7), .ACC_W(16)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_data   (in_data[6:0]),
    .in_last   (in_last),
    .in_mode   (in_mode),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_count (out_count_a),
    .out_sat   (out_sat_a)
  );

  popcount_pipe #(.IN_W(8), .ACC_W(4)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_mode   (in_mode),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_count (out_count_b),
    .out_sat   (out_sat_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Holds one beat on the bus until both instances take it, then parks the
  // bus with junk data to show that invalid cycles are ignored.
  task automatic applyStimulus(input logic [7:0] data, input logic mode, input logic last);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_mode  = mode;
    in_last  = last;
    @(negedge clk);
    while (!(in_ready_a && in_ready_b) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) checkOutput("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_mode  = 1'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on every input handshake, pop on every output handshake,
  // and check that a held result stays put while out_ready is low.
  always @(negedge clk) begin
    logic        ov, os, ir;
    logic [31:0] oc;
    exp_t        e;
    int          cnt, maxv, sum;
    logic        hit;
    string       dn;
    if (rst_n && !in_ready_a) stall_cnt++;
    for (int d = 0; d < 2; d++) begin
      dn   = (d == 0) ? "a" : "b";
      ov   = (d == 0) ? out_valid_a : out_valid_b;
      os   = (d == 0) ? out_sat_a : out_sat_b;
      ir   = (d == 0) ? in_ready_a : in_ready_b;
      oc   = (d == 0) ? 32'(out_count_a) : 32'(out_count_b);
      maxv = (d == 0) ? 65535 : 15;
      if (!rst_n) begin
        exp_q[d].delete();
        acc_m[d]    = 0;
        sticky_m[d] = 1'b0;
        hold_v[d]   = 1'b0;
      end else begin
        if (hold_v[d]) begin
          checkOutput({dn, "_hold_valid"}, 32'(ov), 32'd1);
          checkOutput({dn, "_hold_count"}, oc, hold_c[d]);
          checkOutput({dn, "_hold_sat"}, 32'(os), 32'(hold_s[d]));
        end
        hold_v[d] = ov && !out_ready;
        hold_c[d] = oc;
        hold_s[d] = os;
        if (ov && out_ready) begin
          if (exp_q[d].size() == 0) begin
            checkOutput({dn, "_unexpected_out"}, 32'd1, 32'd0);
          end else begin
            e = exp_q[d].pop_front();
            checkOutput({dn, "_count"}, oc, e.cnt);
            checkOutput({dn, "_sat"}, 32'(os), 32'(e.sat));
          end
        end
        if (in_valid && ir) begin
          cnt = (d == 0) ? $countones(in_data[6:0]) : $countones(in_data);
          if (!in_mode) begin
            e.cnt = 32'(cnt);
            e.sat = 1'b0;
            exp_q[d].push_back(e);
          end else begin
            sum = acc_m[d] + cnt;
            hit = 1'b0;
            if (sum > maxv) begin
              sum = maxv;
              hit = 1'b1;
            end
            if (in_last) begin
              e.cnt = 32'(sum);
              e.sat = sticky_m[d] | hit;
              exp_q[d].push_back(e);
              acc_m[d]    = 0;
              sticky_m[d] = 1'b0;
            end else begin
              acc_m[d]    = sum;
              sticky_m[d] = sticky_m[d] | hit;
            end
          end
        end
      end
    end
  end

  initial begin
    int   lat;
    int   s0;
    int   n;
    logic seen;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid_a", 32'(out_valid_a), 32'd0);
    checkOutput("rst_out_count_a", 32'(out_count_a), 32'd0);
    checkOutput("rst_out_sat_a", 32'(out_sat_a), 32'd0);
    checkOutput("rst_out_valid_b", 32'(out_valid_b), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready_a", 32'(in_ready_a), 32'd1);
    checkOutput("rst_in_ready_b", 32'(in_ready_b), 32'd1);

    // First result appears on the 4th rising edge counting the accept edge.
    in_valid = 1'b1;
    in_data  = 8'h00;
    in_mode  = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid_a && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency_a", 32'(lat), 32'd4);
    idle(3);

    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h7F, 1'b0, 1'b0);
    applyStimulus(8'h55, 1'b0, 1'b0);
    idle(6);

    $display("[TB] backpressure");
    s0 = stall_cnt;
    out_ready = 1'b0;
    fork
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        applyStimulus(8'h01, 1'b0, 1'b0);
        applyStimulus(8'h03, 1'b0, 1'b0);
        applyStimulus(8'h07, 1'b0, 1'b0);
        applyStimulus(8'h0F, 1'b0, 1'b0);
        applyStimulus(8'h1F, 1'b0, 1'b0);
      end
    join
    idle(8);
    checkOutput("in_ready_dropped", 32'(stall_cnt > s0), 32'd1);

    $display("[TB] accumulate");
    applyStimulus(8'h7F, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h03, 1'b1, 1'b1);
    applyStimulus(8'h01, 1'b1, 1'b1);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b1);
    applyStimulus(8'h01, 1'b1, 1'b1);
    applyStimulus(8'h0F, 1'b1, 1'b0);
    applyStimulus(8'h03, 1'b0, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b1);
    idle(8);

    $display("[TB] reset mid-packet");
    applyStimulus(8'h0F, 1'b1, 1'b0);
    applyStimulus(8'h1F, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h03, 1'b1, 1'b0);
    applyStimulus(8'h07, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid_a", 32'(out_valid_a), 32'd0);
    checkOutput("midrst_in_ready_a", 32'(in_ready_a), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid_a || out_valid_b) seen = 1'b1;
    end
    checkOutput("post_reset_quiet", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(8'h01, 1'b1, 1'b1);
    idle(8);

    $display("[TB] random traffic");
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          applyStimulus(8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join

    n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain_a", 32'(exp_q[0].size()), 32'd0);
    checkOutput("drain_b", 32'(exp_q[1].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
